// File: rtl/blkmem_unpack_reader_pkg.sv
// Shared types and helpers for the asymmetric BRAM unpacking reader.
// State values keep the legacy encoding (IDLE=0, WAIT=1, EMIT=2, DONE=3).
package blkmem_unpack_reader_pkg;

    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned PACK_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of a counter/index covering 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blkmem_unpack_reader_lane_ser.sv
// Lane serializer: holds one packed read word and emits its lanes LSB-first
// over valid/ready, flagging the final lane of the final word.
module blkmem_lane_ser
    import blkmem_unpack_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PACK   = PACK_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [PACK*DATA_W-1:0]   word_in,
    input  logic                     last_word,
    input  logic                     ready,
    output logic [DATA_W-1:0]        data,
    output logic                     valid,
    output logic                     last,
    output logic                     word_done
);

    localparam int unsigned LANE_W = idx_w(PACK);

    logic [PACK-1:0][DATA_W-1:0] hold;
    logic [LANE_W-1:0]           lane;
    logic                        final_q;
    logic                        on_last_lane;

    assign on_last_lane = (lane == LANE_W'(PACK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            lane    <= '0;
            valid   <= 1'b0;
            final_q <= 1'b0;
        end else if (load) begin
            hold    <= word_in;
            lane    <= '0;
            valid   <= 1'b1;
            final_q <= last_word;
        end else if (valid && ready) begin
            // The lane index parks on the last lane after the word drains so
            // data stays put until the next load.
            if (on_last_lane) begin
                valid <= 1'b0;
            end else begin
                lane <= lane + 1'b1;
            end
        end
    end

    assign data      = hold[lane];
    assign last      = valid && final_q && on_last_lane;
    assign word_done = valid && ready && on_last_lane;

endmodule

// File: rtl/blkmem_unpack_reader.sv
// Read-side master for the 24-bit-write / 72-bit-read block RAM: fetches
// num_words words from base_addr and streams their samples out LSB lane first.
module blkmem_unpack_reader
    import blkmem_unpack_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PACK   = PACK_DEF,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          num_words,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [PACK*DATA_W-1:0]   mem_dout,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    localparam int unsigned NUM_W = ADDR_W + 1;
    localparam int unsigned LAT_W = idx_w(RD_LAT + 1);

    state_t            state, state_d;
    logic              busy_d, done_d, mem_en_d;
    logic [ADDR_W-1:0] addr_d;
    logic [NUM_W-1:0]  words_left, left_d;
    logic [LAT_W-1:0]  lat_cnt, lat_d;
    logic              capture;
    logic              word_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            words_left <= '0;
            lat_cnt    <= '0;
        end else begin
            state      <= state_d;
            busy       <= busy_d;
            done       <= done_d;
            mem_en     <= mem_en_d;
            mem_addr   <= addr_d;
            words_left <= left_d;
            lat_cnt    <= lat_d;
        end
    end

    // done is raised on entry to DONE so it coincides with that state; a start
    // arriving alongside done therefore lands outside IDLE and is ignored.
    always_comb begin
        state_d  = state;
        busy_d   = busy;
        done_d   = 1'b0;
        mem_en_d = 1'b0;
        addr_d   = mem_addr;
        left_d   = words_left;
        lat_d    = lat_cnt;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    left_d = num_words;
                    lat_d  = '0;
                    if (num_words == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        mem_en_d = 1'b1;
                        addr_d   = base_addr;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_W'(RD_LAT)) begin
                    capture = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    lat_d = lat_cnt + 1'b1;
                end
            end
            ST_EMIT: begin
                if (word_done) begin
                    if (words_left > NUM_W'(1)) begin
                        mem_en_d = 1'b1;
                        addr_d   = mem_addr + 1'b1;
                        left_d   = words_left - 1'b1;
                        lat_d    = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    blkmem_lane_ser #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_lane_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .word_in   (mem_dout),
        .last_word (words_left == NUM_W'(1)),
        .ready     (m_ready),
        .data      (m_data),
        .valid     (m_valid),
        .last      (m_last),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_blkmem_unpack_reader.sv
// Bench for blkmem_unpack_reader: two instances (read latency 2 and 1) share
// stimulus; each has its own BRAM pipeline and is checked against a word-list model.
module tb_blkmem_unpack_reader;

    localparam int AW = 4;
    localparam int DW = 24;
    localparam int PK = 3;
    localparam int WW = PK * DW;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        int            rmode;
        int            exp_fetch;
        int            exp_samp;
        string         name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          m_ready = 1'b0;
    int            rmode = 0;

    logic          busy_a, done_a, en_a, valid_a, last_a;
    logic          busy_b, done_b, en_b, valid_b, last_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [WW-1:0] dout_a, dout_b;
    logic [DW-1:0] data_a, data_b;

    blkmem_unpack_reader #(.ADDR_W(AW), .DATA_W(DW), .PACK(PK), .RD_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy_a), .done(done_a), .mem_en(en_a), .mem_addr(addr_a), .mem_dout(dout_a),
        .m_data(data_a), .m_valid(valid_a), .m_ready(m_ready), .m_last(last_a));

    blkmem_unpack_reader #(.ADDR_W(AW), .DATA_W(DW), .PACK(PK), .RD_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy_b), .done(done_b), .mem_en(en_b), .mem_addr(addr_b), .mem_dout(dout_b),
        .m_data(data_b), .m_valid(valid_b), .m_ready(m_ready), .m_last(last_b));

    // Behavioural BRAM: shared contents, per-instance read pipeline.
    logic [WW-1:0] mem [DEPTH];
    logic [WW-1:0] pa0, pa1, pb0;
    always @(posedge clk) begin
        if (en_a) pa0 <= mem[addr_a];
        pa1 <= pa0;
        if (en_b) pb0 <= mem[addr_b];
    end
    assign dout_a = pa1;
    assign dout_b = pb0;

    always @(posedge clk) begin
        #2;
        case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    logic          mv [2], ml [2], me [2], md [2], mb [2];
    logic [DW-1:0] mdat [2];
    logic [AW-1:0] maddr [2];
    assign mv[0] = valid_a;  assign mv[1] = valid_b;
    assign ml[0] = last_a;   assign ml[1] = last_b;
    assign me[0] = en_a;     assign me[1] = en_b;
    assign md[0] = done_a;   assign md[1] = done_b;
    assign mb[0] = busy_a;   assign mb[1] = busy_b;
    assign mdat[0] = data_a; assign mdat[1] = data_b;
    assign maddr[0] = addr_a; assign maddr[1] = addr_b;

    int    rdlat [2] = '{2, 1};
    string tag [2] = '{"lat2", "lat1"};

    int checks = 0;
    int errors = 0;

    int            ncyc = 0;
    logic [DW:0]   samp [2][64];
    logic [AW-1:0] ens [2][32];
    int            nsamp [2], nen [2], done_cnt [2], busy_cnt [2];
    int            first_valid [2], done_cyc [2], last_hs_cyc [2];
    logic          stall_prev [2], stall_last [2];
    logic [DW-1:0] stall_data [2];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            nsamp[k] = 0; nen[k] = 0; done_cnt[k] = 0; busy_cnt[k] = 0;
            first_valid[k] = -1; done_cyc[k] = -1; last_hs_cyc[k] = -1;
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                stall_prev[k] = 1'b0;
            end else begin
                if (mb[k]) busy_cnt[k]++;
                if (me[k]) begin
                    if (nen[k] < 32) ens[k][nen[k]] = maddr[k];
                    nen[k]++;
                end
                if (mv[k] && first_valid[k] < 0) first_valid[k] = ncyc;
                if (md[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = ncyc;
                end
                if (stall_prev[k])
                    check($sformatf("%s_stall_hold", tag[k]), 64'({mv[k], ml[k], mdat[k]}),
                          64'({1'b1, stall_last[k], stall_data[k]}));
                if (mv[k] && m_ready) begin
                    if (nsamp[k] < 64) samp[k][nsamp[k]] = {ml[k], mdat[k]};
                    nsamp[k]++;
                    last_hs_cyc[k] = ncyc;
                end
                stall_prev[k] = mv[k] && !m_ready;
                stall_data[k] = mdat[k];
                stall_last[k] = ml[k];
            end
        end
    end

    task automatic check_zero(input string nm);
        for (int k = 0; k < 2; k++)
            check($sformatf("%s_%s_outs", nm, tag[k]),
                  64'({mb[k], md[k], me[k], maddr[k], mv[k], ml[k], mdat[k]}), 64'(0));
    endtask

    // Expected stream: every word base..base+num-1 (mod depth), lanes low to high.
    task automatic run_req(input vec_t v);
        int t0, idx;
        logic [WW-1:0] wd;
        logic [DW:0] ex;
        @(posedge clk); #1;
        clear_mon();
        rmode = v.rmode; base_addr = v.base; num_words = (AW+1)'(v.num); start = 1'b1;
        t0 = ncyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && ncyc < t0 + 2000) begin
            @(posedge clk); #1;
            if (done_cnt[0] == 0 && done_cnt[1] == 0 && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                base_addr = AW'($urandom);
                num_words = (AW+1)'($urandom_range(0, DEPTH));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_%s_done_count", v.name, tag[k]), 64'(done_cnt[k]), 64'(1));
            check($sformatf("%s_%s_fetches", v.name, tag[k]), 64'(nen[k]), 64'(v.exp_fetch));
            check($sformatf("%s_%s_samples", v.name, tag[k]), 64'(nsamp[k]), 64'(v.exp_samp));
            for (int i = 0; i < v.num && i < nen[k] && i < 32; i++)
                check($sformatf("%s_%s_addr%0d", v.name, tag[k], i), 64'(ens[k][i]),
                      64'((int'(v.base) + i) % DEPTH));
            for (int w = 0; w < v.num; w++) begin
                wd = mem[(int'(v.base) + w) % DEPTH];
                for (int l = 0; l < PK; l++) begin
                    idx = w * PK + l;
                    ex = {(w == v.num - 1) && (l == PK - 1), wd[l*DW +: DW]};
                    if (idx < nsamp[k] && idx < 64)
                        check($sformatf("%s_%s_samp%0d", v.name, tag[k], idx),
                              64'(samp[k][idx]), 64'(ex));
                end
            end
            if (v.num > 0) begin
                check($sformatf("%s_%s_first_valid", v.name, tag[k]), 64'(first_valid[k]),
                      64'(t0 + rdlat[k] + 3));
                check($sformatf("%s_%s_done_after_last", v.name, tag[k]), 64'(done_cyc[k]),
                      64'(last_hs_cyc[k] + 1));
            end else begin
                check($sformatf("%s_%s_done_cyc", v.name, tag[k]), 64'(done_cyc[k]), 64'(t0 + 2));
                check($sformatf("%s_%s_no_valid", v.name, tag[k]), 64'(first_valid[k]), 64'(-1));
            end
            check($sformatf("%s_%s_busy_cycles", v.name, tag[k]), 64'(busy_cnt[k]),
                  64'(done_cyc[k] - t0 - 1));
        end
    endtask

    vec_t vecs [6];
    vec_t rv;

    initial begin
        int t, n;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        for (int w = 0; w < DEPTH; w++)
            mem[w] = {24'(3*w + 18), 24'(3*w + 17), 24'(3*w + 16)};
        vecs[0] = '{4'd0,  4,  0, 4,  12, "t1_ramp"};
        vecs[1] = '{4'd0,  4,  1, 4,  12, "t2_backpressure"};
        vecs[2] = '{4'd5,  0,  0, 0,  0,  "t3_zero"};
        vecs[3] = '{4'd15, 2,  0, 2,  6,  "t4_wrap"};
        vecs[4] = '{4'd3,  1,  2, 1,  3,  "one_word"};
        vecs[5] = '{4'd7,  16, 2, 16, 48, "full_depth"};
        clear_mon();
        #2;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_req(vecs[i]);

        // Reset while the latency-2 instance stalls on lane 1 of word 1.
        @(posedge clk); #1;
        clear_mon();
        rmode = 0; base_addr = '0; num_words = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = ncyc;
        while (nsamp[0] < 4 && ncyc < t + 500) begin
            @(posedge clk); #1;
        end
        rmode = 3;
        check("t5_reached_stall", 64'(nsamp[0]), 64'(4));
        repeat (2) @(posedge clk);
        #3;
        check("t5_stalled_valid", 64'(valid_a), 64'(1));
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        repeat (3) @(posedge clk);
        #3;
        clear_mon();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t5_%s_no_done", tag[k]), 64'(done_cnt[k]), 64'(0));
            check($sformatf("t5_%s_no_fetch", tag[k]), 64'(nen[k]), 64'(0));
        end
        run_req('{4'd0, 4, 0, 4, 12, "t5_fresh"});

        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < DEPTH; w++)
                mem[w] = {$urandom, $urandom, $urandom};
            n = $urandom_range(0, DEPTH);
            rv = '{AW'($urandom), n, 2, n, n * PK, $sformatf("rand%0d", r)};
            run_req(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
